// File: rtl/jump_decode_stage.sv
// Registered decode stage: tags each accepted instruction with its PC and a jump flag,
// computes the PC-relative target, redirects the PC and squashes wrong-path instructions.
module jump_decode_stage #(
  parameter int unsigned    IW      = 8,
  parameter int unsigned    OPW     = 2,
  parameter logic [OPW-1:0] JUMP_OP = 2'b11,
  parameter int unsigned    AW      = 8,
  parameter int unsigned    FLUSH   = 1,
  parameter int unsigned    CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_instr,
  output logic [AW-1:0]   out_pc,
  output logic            out_jump,
  output logic [AW-1:0]   out_target,
  output logic [CNTW-1:0] jump_count,
  output logic            squashing
);

  localparam int unsigned OW = IW - OPW;

  logic [AW-1:0]   pc_q, pc_d;
  logic [1:0]      squash_q, squash_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [AW-1:0]   opc_q, opc_d;
  logic            jump_q, jump_d;
  logic [AW-1:0]   target_q, target_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          is_jump;
  logic [OW-1:0] off_raw;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] target;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign is_jump = (in_instr[IW-1 -: OPW] == JUMP_OP);
  assign off_raw = in_instr[OW-1:0];
  // Signed size cast sign-extends when AW > OW and truncates otherwise.
  assign off_ext = AW'($signed(off_raw));
  assign target  = pc_q + AW'(1) + off_ext;

  always_comb begin
    pc_d     = pc_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    jump_d   = jump_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (squash_q == 2'd0) begin
        valid_d  = 1'b1;
        instr_d  = in_instr;
        opc_d    = pc_q;
        jump_d   = is_jump;
        target_d = is_jump ? target : '0;
        if (is_jump) begin
          pc_d     = target;
          squash_d = 2'(FLUSH);
          if (cnt_q != {CNTW{1'b1}}) begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end else begin
        // Wrong-path slot: consume and drop, jump opcodes included.
        squash_d = squash_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      squash_q <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      jump_q   <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      jump_q   <= jump_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_pc     = opc_q;
  assign out_jump   = jump_q;
  assign out_target = target_q;
  assign jump_count = cnt_q;
  assign squashing  = (squash_q != 2'd0);

endmodule

// File: tb/tb_jump_decode_stage.sv
// Bench for jump_decode_stage (CNTW=2, FLUSH=1): directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_jump_decode_stage;

  localparam int IW    = 8;
  localparam int AW    = 8;
  localparam int CNTW  = 2;
  localparam int FLUSH = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_instr;
  logic [AW-1:0]   out_pc;
  logic            out_jump;
  logic [AW-1:0]   out_target;
  logic [CNTW-1:0] jump_count;
  logic            squashing;

  always #5 clk = ~clk;

  jump_decode_stage #(
    .IW   (IW),
    .AW   (AW),
    .FLUSH(FLUSH),
    .CNTW (CNTW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_jump  (out_jump),
    .out_target(out_target),
    .jump_count(jump_count),
    .squashing (squashing)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state, plain integers.
  int m_pc, m_sq, m_cnt, m_valid, m_instr, m_opc, m_jump, m_tgt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_sq = 0; m_cnt = 0; m_valid = 0;
    m_instr = 0; m_opc = 0; m_jump = 0; m_tgt = 0;
  endfunction

  function automatic void model_cycle(input int acc, input int ins, input int ordy);
    int op, off, tgt;
    op  = ins / 64;
    off = ins % 64;
    if (off >= 32) off = off - 64;
    tgt = (m_pc + 1 + off + 256) % 256;
    if (m_valid != 0 && ordy != 0) m_valid = 0;
    if (acc != 0) begin
      if (m_sq == 0) begin
        m_valid = 1;
        m_instr = ins;
        m_opc   = m_pc;
        m_jump  = (op == 3) ? 1 : 0;
        m_tgt   = (op == 3) ? tgt : 0;
        if (op == 3) begin
          m_pc  = tgt;
          m_sq  = FLUSH;
          m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end else begin
        m_sq = m_sq - 1;
      end
    end
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("jump_count", jump_count, m_cnt);
    check_eq("squashing", squashing, (m_sq != 0));
    if (m_valid != 0) begin
      check_eq("out_instr", out_instr, m_instr);
      check_eq("out_pc", out_pc, m_opc);
      check_eq("out_jump", out_jump, m_jump);
      check_eq("out_target", out_target, m_tgt);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_instr"}, out_instr, 0);
    check_eq({tag, "_pc"}, out_pc, 0);
    check_eq({tag, "_jump"}, out_jump, 0);
    check_eq({tag, "_target"}, out_target, 0);
    check_eq({tag, "_count"}, jump_count, 0);
    check_eq({tag, "_squashing"}, squashing, 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic iv, input logic [7:0] ins, input logic ordy);
    int exp_ready;
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    #1;
    exp_ready = (m_valid == 0 || ordy) ? 1 : 0;
    check_eq("in_ready", in_ready, exp_ready);
    model_cycle((iv && exp_ready != 0) ? 1 : 0, int'(ins), int'(ordy));
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    model_reset();
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Straight-line instructions.
    step(1'b1, 8'h00, 1'b1); check_eq("seq_pc0", out_pc, 0);
    step(1'b1, 8'h01, 1'b1); check_eq("seq_pc1", out_pc, 1);
    step(1'b1, 8'h02, 1'b1); check_eq("seq_pc2", out_pc, 2);
    check_eq("seq_jump", out_jump, 0);
    step(1'b0, 8'h00, 1'b1); check_eq("seq_drain", out_valid, 0);
    check_eq("seq_count", jump_count, 0);

    // Forward jump then one squashed slot.
    do_reset();
    step(1'b1, 8'hC5, 1'b1);
    check_eq("fwd_jump", out_jump, 1);
    check_eq("fwd_target", out_target, 6);
    check_eq("fwd_squashing", squashing, 1);
    step(1'b1, 8'h00, 1'b1); check_eq("fwd_squashed", out_valid, 0);
    step(1'b1, 8'h00, 1'b1);
    check_eq("fwd_next_pc", out_pc, 6);
    check_eq("fwd_count", jump_count, 1);

    // Backward jump; jump opcode in the squash slot is ignored.
    do_reset();
    repeat (4) step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hFE, 1'b1); check_eq("bwd_target", out_target, 3);
    step(1'b1, 8'hC1, 1'b1);
    check_eq("bwd_squash_valid", out_valid, 0);
    check_eq("bwd_squash_count", jump_count, 1);
    step(1'b1, 8'h00, 1'b1); check_eq("bwd_next_pc", out_pc, 3);

    // Backpressure.
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    repeat (3) begin
      step(1'b1, 8'h02, 1'b0);
      check_eq("bp_hold_instr", out_instr, 8'h01);
    end
    step(1'b1, 8'h02, 1'b1);
    check_eq("bp_instr", out_instr, 8'h02);
    check_eq("bp_pc", out_pc, 1);
    step(1'b0, 8'h00, 1'b1);

    // Counter saturation at CNTW=2.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'hC0, 1'b1);
      check_eq("sat_count", jump_count, exp_cnt[k]);
      step(1'b1, 8'h00, 1'b1);
    end

    // Address wrap: 0 -> 254 via off=-3, then 254+1+3 wraps to 2.
    do_reset();
    step(1'b1, 8'hFD, 1'b1); check_eq("wrap_t254", out_target, 254);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    check_eq("wrap_pc", out_pc, 254);
    check_eq("wrap_target", out_target, 2);

    // Asynchronous reset in the middle of a squash window.
    do_reset();
    step(1'b1, 8'hC5, 1'b0);
    check_eq("mid_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h00, 1'b1);
    check_eq("post_rst_pc", out_pc, 0);
    check_eq("post_rst_sq", squashing, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_decode_stage.md
Name: jump_decode_stage

Overview:
- Registered, parametrised successor to the combinational jump detector.
- Sits between instruction fetch and execute, and accepts one instruction per handshake.
- Tags each instruction with its PC and a jump flag; computes the PC-relative jump target.
- Redirects its internal PC on a jump and squashes a configurable number of wrong-path instructions after each jump.
- Keeps a saturating count of jumps.

Parameters:
IW, 8, instruction width in bits
OPW, 2, opcode field width; the opcode is instr[IW-1 -: OPW]
JUMP_OP, 2'b11, opcode value that marks a jump (OPW bits wide)
AW, 8, PC / target width
FLUSH, 1, instructions squashed after a jump (legal range 0..3)
CNTW, 8, jump counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  IW  instruction
out_valid  out  1  output register holds a valid instruction
out_ready  in  1  downstream accepts
out_instr  out  IW  registered instruction
out_pc  out  AW  PC of out_instr
out_jump  out  1  out_instr is a jump
out_target  out  AW  jump target; 0 when out_jump=0
jump_count  out  CNTW  saturating count of non-squashed jumps
squashing  out  1  squash counter non-zero

Behaviour:
- Reset (async assert, sync release): pc=0, squash_cnt=0, out_valid=0, out_instr=0, out_pc=0, out_jump=0, out_target=0, jump_count=0, squashing=0.
- Reset mid-operation discards any held output and any remaining squash window.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready.
- No combinational path from in_valid to out_*.
- Decode on accept:
  - is_jump = (in_instr[IW-1 -: OPW] == JUMP_OP).
  - off = in_instr[IW-OPW-1:0], sign-extended (or truncated) to AW.
  - target = pc + 1 + off, modulo 2^AW; wrap-around is silent.
- Accept while squash_cnt == 0 (normal):
  - Output register loads instr, pc, is_jump, and target (or 0 when not a jump); out_valid = 1.
  - If is_jump: pc <= target, squash_cnt <= FLUSH, jump_count += 1 (saturates at 2^CNTW-1, no wrap).
  - Otherwise: pc <= pc+1.
- Accept while squash_cnt > 0 (squash):
  - Instruction is consumed and dropped; the output register is not loaded.
  - out_valid clears if out_ready was high this cycle, else holds.
  - pc unchanged, squash_cnt -= 1.
  - A jump opcode here is ignored: no redirect, no count.
- No accept:
  - If out_valid && out_ready, out_valid <= 0.
  - All other state holds.
  - out_* stay stable while out_valid && !out_ready.
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready is held high.
- FLUSH = 0: no squash window; back-to-back jumps each redirect.
- squashing = (squash_cnt != 0), registered.

Test Plan:
- Reset, then feed 0x00, 0x01, 0x02 with out_ready=1 -> out_pc 0,1,2; out_jump=0 each; out_valid one cycle after each accept; jump_count=0.
- At pc=0 feed 0xC5 (jump, off=+5), then 0x00 and 0x00 -> out_jump=1, out_target=6. The first 0x00 is squashed: no output, squashing=1 during it. The second 0x00 is output with out_pc=6. jump_count=1.
- At pc=4 feed 0xFE (off=-2) -> out_target=3. Then feed 0xC1 while squashing -> no output, jump_count unchanged. The next instruction has out_pc=3.
- Backpressure: out_ready=0 for 3 cycles after the first accept, in_valid=1 with 0x01, 0x02 -> in_ready=0, out_instr stays 0x01 and stable. After release, 0x02 follows with out_pc=1; no loss or duplication.
- CNTW=2 bench: 5 non-squashed jumps -> jump_count 1,2,3,3,3. AW wrap: pc=254 with 0xC3 -> out_target=2.
- Assert rst_n=0 mid-squash with out_valid=1 -> all outputs 0 immediately. After release, the first accept gets out_pc=0 and squashing=0.
